// File: rtl/bridge_pkg.sv
// Shared types and helpers for the MMIO bridge.
package bridge_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone,
    StErr
  } state_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_decode.sv
// Combinational priority address decoder: lowest matching device index wins.
module bridge_decode
  import bridge_pkg::*;
#(
  parameter int unsigned                NUM_DEV  = 3,
  parameter int unsigned                IDX_W    = 2,
  parameter logic [NUM_DEV*DATA_W-1:0]  DEV_BASE = '0,
  parameter logic [NUM_DEV*DATA_W-1:0]  DEV_MASK = '0
) (
  input  logic [DATA_W-1:0]  addr,
  output logic               hit,
  output logic [NUM_DEV-1:0] sel,
  output logic [IDX_W-1:0]   index,
  output logic [DATA_W-1:0]  offset
);

  // Scan upward and freeze on the first hit so overlaps resolve to the lowest index.
  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    index  = '0;
    offset = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (!hit && ((addr & DEV_MASK[i*DATA_W +: DATA_W]) == DEV_BASE[i*DATA_W +: DATA_W])) begin
        hit    = 1'b1;
        sel[i] = 1'b1;
        index  = IDX_W'(i);
        offset = addr & ~DEV_MASK[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Request/acknowledge MMIO bridge from the CPU data port to NUM_DEV device
// channels, with per-device wait states, a bus-error timeout and synchronised
// interrupt lines.
module mmio_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned               NUM_DEV  = 3,
  parameter int unsigned               TIMEOUT  = 16,
  parameter logic [NUM_DEV*DATA_W-1:0] DEV_BASE = {32'h7F20, 32'h7F10, 32'h7F00},
  parameter logic [NUM_DEV*DATA_W-1:0] DEV_MASK = {3{32'hFFFF_FFF0}}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic [DATA_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic [BE_W-1:0]           cpu_we,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ack,
  output logic                      cpu_err,
  output logic [NUM_DEV-1:0]        dev_sel,
  output logic [DATA_W-1:0]         dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  output logic [BE_W-1:0]           dev_we,
  input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]        dev_ready,
  input  logic [NUM_DEV-1:0]        dev_irq,
  output logic [NUM_DEV-1:0]        hwint
);

  localparam int unsigned IdxW = cnt_width(NUM_DEV);
  localparam int unsigned CntW = cnt_width(TIMEOUT);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_DEV-1:0]  sel_q;
  logic [IdxW-1:0]     idx_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     we_q;
  logic [NUM_DEV-1:0]  irq_meta_q, irq_sync_q;

  logic                dec_hit;
  logic [NUM_DEV-1:0]  dec_sel;
  logic [IdxW-1:0]     dec_idx;
  logic [DATA_W-1:0]   dec_offset;
  logic                accept;
  logic                ready;
  logic [DATA_W-1:0]   rd_slice;

  bridge_decode #(
    .NUM_DEV  (NUM_DEV),
    .IDX_W    (IdxW),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_decode (
    .addr   (cpu_addr),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .index  (dec_idx),
    .offset (dec_offset)
  );

  // Only the latched device may complete the access; other ready lines are ignored.
  assign ready = |(dev_ready & sel_q);

  // Pick the read data slice of the latched device.
  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (idx_q == IdxW'(i)) rd_slice = dev_rdata[i*DATA_W +: DATA_W];
    end
  end

  // Next-state, wait counter and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cpu_req) begin
          accept = 1'b1;
          if (dec_hit) begin
            state_d = StWait;
          end else begin
            state_d = StErr;
            rdata_d = '0;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Ready has priority over a coincident timeout.
        if (ready) begin
          state_d = StDone;
          rdata_d = rd_slice;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StErr;
          rdata_d = '0;
          cnt_d   = '0;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM, counter and read-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request latches: captured once on accept and held for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else if (accept) begin
      sel_q   <= dec_sel;
      idx_q   <= dec_idx;
      addr_q  <= dec_offset;
      wdata_q <= cpu_wdata;
      we_q    <= cpu_we;
    end
  end

  // Two-flop interrupt synchroniser, independent of the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_meta_q <= '0;
      irq_sync_q <= '0;
    end else begin
      irq_meta_q <= dev_irq;
      irq_sync_q <= irq_meta_q;
    end
  end

  // Output decode from registered state.
  always_comb begin
    dev_sel   = (state_q == StWait) ? sel_q : '0;
    dev_we    = (state_q == StWait) ? we_q  : '0;
    dev_addr  = addr_q;
    dev_wdata = wdata_q;
    cpu_ack   = (state_q == StDone) || (state_q == StErr);
    cpu_err   = (state_q == StErr);
    cpu_rdata = rdata_q;
    hwint     = irq_sync_q;
  end

endmodule
